// File: rtl/tx_defs.sv
// ---------------------------------------------------------------------------
// tx_defs
// Shared definitions for the TX sample playback block: buffer geometry,
// sample width and the playback FSM state encoding.
// ---------------------------------------------------------------------------
package tx_defs;

    // Waveform buffer depth in samples and the address width that covers it
    localparam int MEMORY_LENGTH = 510;
    localparam int ADDR_WIDTH    = 9;
    localparam int DATA_WIDTH    = 16;

    // Playback FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    // True for the states in which the block reports itself busy
    function automatic logic state_is_busy(input tx_state_t st);
        return (st == ST_PRIME) || (st == ST_PLAY);
    endfunction

endpackage

// File: rtl/tx_BRAM.sv
// ---------------------------------------------------------------------------
// tx_BRAM
// Simple dual-port synchronous RAM: one write port, one read port, both on
// the same clock, one-cycle read latency. The read register holds its value
// while re is low.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable (updates the read register)
//   raddr  : read address
//   rdata  : registered read data
// ---------------------------------------------------------------------------
module tx_BRAM #(
    parameter int DEPTH = tx_defs::MEMORY_LENGTH,
    parameter int AW    = tx_defs::ADDR_WIDTH,
    parameter int DW    = tx_defs::DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [DW-1:0] rdata_r;

    // Storage array write port; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DW{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/tx_sample_playback.sv
// ---------------------------------------------------------------------------
// tx_sample_playback
// Loads a waveform into an internal buffer while idle, then plays it out one
// sample per sample_tick, either once (ending with a done pulse) or looped
// until aborted.
//
// Ports:
//   ctx_clk     : clock, rising edge
//   rtx_rst_n   : asynchronous active-low reset
//   etx_en      : block enable, low freezes all state and drops strobes
//   wr_en       : write wr_data at the write pointer (IDLE only)
//   wr_data     : signed 16-bit sample to store
//   wr_clr      : clear write pointer and sample count (IDLE only)
//   start       : playback request (IDLE, non-empty buffer)
//   loop_en     : repeat the waveform until aborted
//   abort       : stop playback without a done pulse
//   sample_tick : DAC sample-rate strobe
//   data_out    : current output sample, holds between ticks
//   data_valid  : one-cycle pulse per new data_out value
//   busy        : high in PRIME and PLAY
//   done        : one-cycle pulse at the end of a non-looped playback
// ---------------------------------------------------------------------------
module tx_sample_playback #(
    parameter int MEMORY_LENGTH = tx_defs::MEMORY_LENGTH,
    parameter int ADDR_WIDTH    = tx_defs::ADDR_WIDTH
) (
    input  logic               ctx_clk,
    input  logic               rtx_rst_n,
    input  logic               etx_en,
    input  logic               wr_en,
    input  logic signed [15:0] wr_data,
    input  logic               wr_clr,
    input  logic               start,
    input  logic               loop_en,
    input  logic               abort,
    input  logic               sample_tick,
    output logic signed [15:0] data_out,
    output logic               data_valid,
    output logic               busy,
    output logic               done
);

    import tx_defs::*;

    // Count must reach MEMORY_LENGTH itself; compare width covers both pointer and count
    localparam int CW   = $clog2(MEMORY_LENGTH + 1);
    localparam int CMPW = (CW > ADDR_WIDTH) ? CW : ADDR_WIDTH;

    tx_state_t               state_r;
    tx_state_t               state_s;
    logic [ADDR_WIDTH-1:0]   wr_ptr_r;
    logic [ADDR_WIDTH-1:0]   wr_ptr_s;
    logic [ADDR_WIDTH-1:0]   rd_ptr_r;
    logic [ADDR_WIDTH-1:0]   raddr_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_s;
    logic signed [15:0]      data_out_r;
    logic signed [15:0]      data_out_s;
    logic                    data_valid_r;
    logic                    data_valid_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    done_s;
    logic                    ram_we_s;
    logic [15:0]             ram_rdata_s;
    logic                    last_s;
    logic [CMPW-1:0]         rd_ext_s;
    logic [CMPW-1:0]         cnt_ext_s;

    tx_BRAM #(
        .DEPTH (MEMORY_LENGTH),
        .AW    (ADDR_WIDTH),
        .DW    (16)
    ) u_bram (
        .clk   (ctx_clk),
        .rst_n (rtx_rst_n),
        .we    (ram_we_s & etx_en),
        .waddr (wr_ptr_r),
        .wdata (wr_data),
        .re    (etx_en),
        .raddr (raddr_s),
        .rdata (ram_rdata_s)
    );

    // Detect that the prefetched sample is the last one of the waveform
    always_comb begin
        rd_ext_s  = CMPW'(rd_ptr_r);
        cnt_ext_s = CMPW'(cnt_r);
        last_s    = ((rd_ext_s + CMPW'(1'b1)) == cnt_ext_s);
    end

    // Next-state, pointer, read-address and output logic.
    // rd_ptr_r always names the sample sitting in the RAM read register, so
    // on a tick the read address already moves to the following sample and
    // back-to-back ticks see fresh data with no gap.
    always_comb begin
        state_s      = state_r;
        wr_ptr_s     = wr_ptr_r;
        cnt_s        = cnt_r;
        raddr_s      = rd_ptr_r;
        data_out_s   = data_out_r;
        data_valid_s = 1'b0;
        done_s       = 1'b0;
        ram_we_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                raddr_s = {ADDR_WIDTH{1'b0}};
                if (wr_clr) begin
                    wr_ptr_s = {ADDR_WIDTH{1'b0}};
                    cnt_s    = {CW{1'b0}};
                end else if (wr_en) begin
                    ram_we_s = 1'b1;
                    if (wr_ptr_r == ADDR_WIDTH'(MEMORY_LENGTH - 1)) begin
                        wr_ptr_s = {ADDR_WIDTH{1'b0}};
                    end else begin
                        wr_ptr_s = wr_ptr_r + ADDR_WIDTH'(1'b1);
                    end
                    if (cnt_r == CW'(MEMORY_LENGTH)) begin
                        cnt_s = cnt_r;
                    end else begin
                        cnt_s = cnt_r + CW'(1'b1);
                    end
                end else begin
                    wr_ptr_s = wr_ptr_r;
                end
                if (start && (cnt_r != {CW{1'b0}})) begin
                    state_s = ST_PRIME;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_PRIME: begin
                // Read of sample 0 is in flight; ticks here are dropped
                raddr_s = {ADDR_WIDTH{1'b0}};
                if (abort) begin
                    state_s    = ST_IDLE;
                    data_out_s = 16'sd0;
                end else begin
                    state_s = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (abort) begin
                    state_s    = ST_IDLE;
                    data_out_s = 16'sd0;
                    raddr_s    = {ADDR_WIDTH{1'b0}};
                end else if (sample_tick) begin
                    data_out_s   = $signed(ram_rdata_s);
                    data_valid_s = 1'b1;
                    if (last_s) begin
                        raddr_s = {ADDR_WIDTH{1'b0}};
                        if (loop_en) begin
                            state_s = ST_PLAY;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        raddr_s = rd_ptr_r + ADDR_WIDTH'(1'b1);
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end

            ST_DONE: begin
                raddr_s    = {ADDR_WIDTH{1'b0}};
                done_s     = 1'b1;
                data_out_s = 16'sd0;
                state_s    = ST_IDLE;
            end

            default: begin
                raddr_s    = {ADDR_WIDTH{1'b0}};
                data_out_s = 16'sd0;
                state_s    = ST_IDLE;
            end
        endcase
    end

    // State, pointers and registered outputs; disable holds state and drops strobes
    always_ff @(posedge ctx_clk or negedge rtx_rst_n) begin
        if (!rtx_rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
            cnt_r        <= {CW{1'b0}};
            data_out_r   <= 16'sd0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (etx_en) begin
            state_r      <= state_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= raddr_s;
            cnt_r        <= cnt_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            busy_r       <= state_is_busy(state_s);
            done_r       <= done_s;
        end else begin
            data_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_tx_sample_playback.sv
// ---------------------------------------------------------------------------
// tb_tx_sample_playback
// Self-checking bench: a cycle-level behavioural model of the playback rules
// runs alongside the DUT and a compare process checks every output on every
// falling edge. Directed scenarios add literal expectations on the played
// sample sequence, done pulses and busy behaviour.
// ---------------------------------------------------------------------------
module tb_tx_sample_playback;

    localparam int ML = 510;
    localparam int P_IDLE  = 0;
    localparam int P_PRIME = 1;
    localparam int P_PLAY  = 2;
    localparam int P_DONE  = 3;

    logic               ctx_clk;
    logic               rtx_rst_n;
    logic               etx_en;
    logic               wr_en;
    logic signed [15:0] wr_data;
    logic               wr_clr;
    logic               start;
    logic               loop_en;
    logic               abort;
    logic               sample_tick;
    logic signed [15:0] data_out;
    logic               data_valid;
    logic               busy;
    logic               done;

    tx_sample_playback dut (
        .ctx_clk     (ctx_clk),
        .rtx_rst_n   (rtx_rst_n),
        .etx_en      (etx_en),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_clr      (wr_clr),
        .start       (start),
        .loop_en     (loop_en),
        .abort       (abort),
        .sample_tick (sample_tick),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .done        (done)
    );

    initial ctx_clk = 1'b0;
    always #5 ctx_clk = ~ctx_clk;

    // Behavioural model state
    int m_mem [0:ML-1];
    int m_wp, m_cnt, m_phase, m_idx;
    int m_dout, m_valid, m_busy, m_done;

    // Bookkeeping
    int total, bad;
    int got_q [$];
    int done_cnt;
    int busy_seen;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wp = 0; m_cnt = 0; m_phase = P_IDLE; m_idx = 0;
        m_dout = 0; m_valid = 0; m_busy = 0; m_done = 0;
    endtask

    // One rising edge of the specified behaviour, using the applied inputs
    task automatic model_update();
        int c0;
        m_valid = 0;
        m_done  = 0;
        if (etx_en) begin
            case (m_phase)
                P_IDLE: begin
                    c0 = m_cnt;
                    if (wr_clr) begin
                        m_wp = 0; m_cnt = 0;
                    end else if (wr_en) begin
                        m_mem[m_wp] = int'(wr_data);
                        m_wp  = (m_wp + 1) % ML;
                        m_cnt = (m_cnt < ML) ? m_cnt + 1 : ML;
                    end
                    if (start && c0 > 0) m_phase = P_PRIME;
                end
                P_PRIME: begin
                    if (abort) begin m_phase = P_IDLE; m_dout = 0; end
                    else begin m_phase = P_PLAY; m_idx = 0; end
                end
                P_PLAY: begin
                    if (abort) begin
                        m_phase = P_IDLE; m_dout = 0;
                    end else if (sample_tick) begin
                        m_dout  = m_mem[m_idx];
                        m_valid = 1;
                        if (m_idx == m_cnt - 1) begin
                            if (loop_en) m_idx = 0;
                            else m_phase = P_DONE;
                        end else begin
                            m_idx++;
                        end
                    end
                end
                default: begin
                    m_done = 1; m_dout = 0; m_phase = P_IDLE;
                end
            endcase
            m_busy = (m_phase == P_PRIME || m_phase == P_PLAY) ? 1 : 0;
        end
    endtask

    // Per-cycle comparison of the DUT against the model on falling edges
    task automatic compare_loop();
        forever begin
            @(negedge ctx_clk);
            check("data_out",   int'(data_out),   m_dout);
            check("data_valid", int'(data_valid), m_valid);
            check("busy",       int'(busy),       m_busy);
            check("done",       int'(done),       m_done);
            if (data_valid) got_q.push_back(int'(data_out));
            if (done) done_cnt++;
            if (busy) busy_seen = 1;
        end
    endtask

    // Advance one clock: model follows the edge, return at the next falling edge
    task automatic cyc();
        @(posedge ctx_clk);
        model_update();
        @(negedge ctx_clk);
    endtask

    task automatic quiet();
        etx_en = 1'b1; wr_en = 1'b0; wr_data = 16'sd0; wr_clr = 1'b0;
        start = 1'b0; abort = 1'b0; sample_tick = 1'b0;
    endtask

    task automatic write_sample(input int v);
        wr_en = 1'b1; wr_data = 16'(v); cyc(); wr_en = 1'b0;
    endtask

    task automatic clear_buf();
        wr_clr = 1'b1; cyc(); wr_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic play(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            sample_tick = ((i % period) == (period - 1));
            cyc();
        end
        sample_tick = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; cyc(); abort = 1'b0; cyc();
    endtask

    task automatic check_seq(input string name, input int exp_q [$]);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_data_out"},   int'(data_out),   0);
        check({name, "_data_valid"}, int'(data_valid), 0);
        check({name, "_busy"},       int'(busy),       0);
        check({name, "_done"},       int'(done),       0);
    endtask

    initial begin
        int lp;
        total = 0; bad = 0; done_cnt = 0; busy_seen = 0;
        rtx_rst_n = 1'b0;
        loop_en = 1'b0;
        quiet();
        model_reset();
        for (int i = 0; i < ML; i++) m_mem[i] = 0;
        #1;
        check_outputs_zero("reset");
        fork
            compare_loop();
        join_none
        @(negedge ctx_clk);
        #2 rtx_rst_n = 1'b1;
        @(negedge ctx_clk);

        // Single playback of four samples, tick every third cycle
        write_sample(100); write_sample(-200); write_sample(300); write_sample(-400);
        got_q.delete(); done_cnt = 0;
        pulse_start();
        play(20, 3);
        check_seq("oneshot", '{100, -200, 300, -400});
        check("oneshot_done_cnt", done_cnt, 1);
        check("oneshot_end_data", int'(data_out), 0);
        check("oneshot_end_busy", int'(busy), 0);

        // Replay without reload
        got_q.delete();
        pulse_start();
        play(16, 2);
        check_seq("replay", '{100, -200, 300, -400});

        // Start with an empty buffer is ignored
        clear_buf();
        got_q.delete(); busy_seen = 0;
        pulse_start();
        play(10, 1);
        check("empty_busy_seen", busy_seen, 0);
        check("empty_valids", got_q.size(), 0);

        // Looped playback of three samples, then abort
        write_sample(100); write_sample(-200); write_sample(300);
        loop_en = 1'b1;
        got_q.delete(); done_cnt = 0;
        pulse_start();
        play(24, 3);
        check_seq("loop", '{100, -200, 300, 100, -200, 300, 100, -200});
        do_abort();
        check("loop_abort_done_cnt", done_cnt, 0);
        check("loop_abort_busy", int'(busy), 0);
        check("loop_abort_data", int'(data_out), 0);
        loop_en = 1'b0;

        // Tick coincident with PRIME is dropped
        got_q.delete();
        pulse_start();
        sample_tick = 1'b1; cyc();
        sample_tick = 1'b0; cyc();
        sample_tick = 1'b1; cyc();
        sample_tick = 1'b0; cyc(); cyc();
        check("prime_tick_count", got_q.size(), 1);
        if (got_q.size() > 0) check("prime_tick_first", got_q[0], 100);
        do_abort();

        // Buffer wrap: 512 writes keep 510 samples, first two overwritten
        clear_buf();
        for (int i = 0; i < 512; i++) write_sample(i * 7 - 1000);
        got_q.delete(); done_cnt = 0;
        pulse_start();
        play(530, 1);
        check("wrap_len", got_q.size(), 510);
        if (got_q.size() == 510) begin
            check("wrap_s0", got_q[0], 2570);
            check("wrap_s1", got_q[1], 2577);
            check("wrap_s2", got_q[2], -986);
            check("wrap_s509", got_q[509], 2563);
        end
        check("wrap_done_cnt", done_cnt, 1);

        // Clear together with a write leaves an empty buffer
        wr_clr = 1'b1; wr_en = 1'b1; wr_data = 16'sd55; cyc();
        wr_clr = 1'b0; wr_en = 1'b0;
        busy_seen = 0;
        pulse_start();
        play(6, 1);
        check("clr_wr_busy_seen", busy_seen, 0);

        // Reset in the middle of playback
        write_sample(100); write_sample(-200); write_sample(300); write_sample(-400);
        done_cnt = 0;
        pulse_start();
        play(7, 3);
        check("pre_reset_busy", int'(busy), 1);
        #2 rtx_rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs_zero("midplay_reset");
        @(negedge ctx_clk);
        #2 rtx_rst_n = 1'b1;
        @(negedge ctx_clk);
        check("reset_done_cnt", done_cnt, 0);
        write_sample(5); write_sample(-6); write_sample(7); write_sample(-8);
        got_q.delete();
        pulse_start();
        play(15, 3);
        check_seq("post_reset", '{5, -6, 7, -8});
        check("post_reset_done_cnt", done_cnt, 1);

        // Randomised traffic against the model
        for (int it = 0; it < 30; it++) begin
            lp = $urandom_range(0, 1);
            loop_en = lp[0];
            for (int c = 0; c < 80; c++) begin
                etx_en      = ($urandom_range(0, 9) != 0);
                wr_en       = ($urandom_range(0, 3) == 0);
                wr_data     = 16'($urandom_range(0, 65535));
                wr_clr      = ($urandom_range(0, 59) == 0);
                start       = ($urandom_range(0, 9) == 0);
                abort       = ($urandom_range(0, 49) == 0);
                sample_tick = ($urandom_range(0, 2) == 0);
                cyc();
            end
            quiet();
            do_abort();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_sample_playback.md
TX_SAMPLE_PLAYBACK -- requirements
Module: tx_sample_playback

Interface
REQ-001 Parameter MEMORY_LENGTH, default 510, is the waveform buffer depth in samples.
REQ-002 Parameter ADDR_WIDTH, default 9, is the buffer address width; 2^ADDR_WIDTH SHALL be >= MEMORY_LENGTH.
REQ-003 ctx_clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rtx_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 etx_en  in  1  block enable; low freezes all state.
REQ-006 wr_en  in  1  write wr_data at the write pointer.
REQ-007 wr_data  in  16 signed  waveform sample to store.
REQ-008 wr_clr  in  1  clears the write pointer and the sample count.
REQ-009 start  in  1  single-cycle playback request.
REQ-010 loop_en  in  1  repeat the waveform until aborted.
REQ-011 abort  in  1  stop playback.
REQ-012 sample_tick  in  1  DAC sample-rate strobe.
REQ-013 data_out  out  16 signed  current output sample.
REQ-014 data_valid  out  1  one-cycle pulse per new data_out value.
REQ-015 busy  out  1  high in PRIME and PLAY.
REQ-016 done  out  1  one-cycle pulse at non-loop playback end.

Function
REQ-017 FSM states: IDLE, PRIME, PLAY, DONE; etx_en low SHALL hold state, pointers, and outputs, and drop strobes.
REQ-018 Load, IDLE only: wr_en writes at wr_ptr; wr_ptr increments and wraps from MEMORY_LENGTH-1 to 0; sample_count increments and saturates at MEMORY_LENGTH.
REQ-019 wr_en outside IDLE SHALL be ignored; wr_clr in IDLE zeroes wr_ptr and sample_count; wr_clr and wr_en together SHALL clear and discard the write.
REQ-020 IDLE->PRIME on start with sample_count>0; start with sample_count==0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-021 PRIME issues a read at address 0 (one-cycle read latency) and SHALL go to PLAY after exactly 1 cycle; sample_tick in PRIME SHALL be dropped.
REQ-022 PLAY: on sample_tick, data_out takes the prefetched sample, data_valid pulses the next cycle, and rd_ptr advances to prefetch the following sample.
REQ-023 After index sample_count-1 is output: with loop_en=1, rd_ptr wraps to 0 with no gap and no extra state; with loop_en=0, go to DONE.
REQ-024 DONE lasts 1 cycle, pulses done, sets data_out to 0, then returns to IDLE.
REQ-025 abort in PRIME or PLAY SHALL go to IDLE next cycle, set data_out to 0, and not pulse done; abort beats a simultaneous sample_tick.
REQ-026 data_out SHALL hold between ticks; sample_count is unchanged by playback, so a replay needs no reload.

Reset
REQ-027 rtx_rst_n low SHALL immediately give: state IDLE; wr_ptr, rd_ptr, sample_count 0; data_out 0; data_valid, busy, done 0.
REQ-028 Reset mid-playback SHALL abort with no done pulse; buffer contents are unspecified after reset.

Structure
REQ-029 The shared package tx_defs SHALL hold MEMORY_LENGTH, ADDR_WIDTH, and the FSM state encodings.
REQ-030 Storage SHALL be one sub-module, tx_BRAM: a simple dual-port synchronous RAM, 16-bit data, one-cycle read latency.

Verification
REQ-031 Load 4 samples {100,-200,300,-400}, start, tick every 3 cycles -> data_valid with 100,-200,300,-400, then done, data_out 0, IDLE.
REQ-032 start with sample_count=0 -> busy stays 0, no data_valid.
REQ-033 Load 3 samples, loop_en=1, 8 ticks -> 100,-200,300,100,-200,300,100,-200; abort -> IDLE, no done.
REQ-034 Tick coincident with the PRIME cycle -> dropped; first data_valid on the next tick carries sample 0.
REQ-035 Write 512 samples -> wr_ptr wraps after 510, sample_count=510, samples 0-1 overwritten; wr_clr with wr_en -> count 0.
REQ-036 Assert rtx_rst_n low mid-PLAY and deassert it -> all outputs 0 immediately, no done; replay after reload is correct.
